// File: rtl/multi_delay.sv
// -----------------------------------------------------------------------------
// multi_delay
//
// Bank of NCH independent programmable delay/period channels. Each channel owns
// a period register P, a counter and a three-state FSM (IDLE / COUNT / DONE).
// While counting, the counter runs 0..P and the channel raises `sig` for the
// one cycle in which the counter equals P. In periodic mode it then restarts
// from 0, so pulses recur every P+1 cycles. In one-shot mode it parks in DONE
// until its enable drops. All channels share a single period write port.
//
// If P is rewritten below the value the counter has already reached, the
// channel is overrun. It then reports neither `sig` nor `flg`, restarts its
// count from 0 on the next edge and sets a sticky error flag. Because of this
// restart the counter never runs past P, so it can never wrap.
//
// Parameters
//   NCH        number of channels (1..16)
//   CBITS      counter / period width
//   RST_PERIOD period loaded into every channel by reset (must fit in CBITS)
//   CHBITS     derived channel-select width, max(1, clog2(NCH)); not to be set
//
// Ports
//   clk      in   1       sole clock, rising edge
//   rst      in   1       asynchronous active-high reset
//   en       in   NCH     per-channel run enable (level)
//   mode     in   NCH     per-channel mode: 0 periodic, 1 one-shot
//   wr_en    in   1       period write strobe
//   wr_ch    in   CHBITS  channel addressed by the write; wr_ch >= NCH is ignored
//   wr_data  in   CBITS   new period value
//   err_clr  in   NCH     per-channel sticky error clear
//   sig      out  NCH     terminal-count pulse (COUNT and cnt == P)
//   flg      out  NCH     counting and below terminal count (COUNT and cnt < P)
//   err      out  NCH     sticky overrun error
//   done     out  NCH     one-shot completed (state DONE)
// -----------------------------------------------------------------------------
module multi_delay #(
  parameter int NCH        = 4,
  parameter int CBITS      = 17,
  parameter int RST_PERIOD = 100000,
  localparam int CHBITS    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    en,
  input  logic [NCH-1:0]    mode,
  input  logic              wr_en,
  input  logic [CHBITS-1:0] wr_ch,
  input  logic [CBITS-1:0]  wr_data,
  input  logic [NCH-1:0]    err_clr,
  output logic [NCH-1:0]    sig,
  output logic [NCH-1:0]    flg,
  output logic [NCH-1:0]    err,
  output logic [NCH-1:0]    done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [CBITS-1:0] RST_P = CBITS'(RST_PERIOD);

  // ---------------------------------------------------------------------------
  // Shared write port decode. Comparing the select against each channel index
  // means an out-of-range wr_ch simply matches no channel.
  // ---------------------------------------------------------------------------
  logic [NCH-1:0] wr_hit;

  // NOTE: every signal assigned in always_comb gets a default on entry, so no
  // path through the block can leave it holding a value and infer a latch.
  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < NCH; i++) begin
      if (wr_en && (int'(wr_ch) == i)) begin
        wr_hit[i] = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel datapath and FSM
  // ---------------------------------------------------------------------------
  for (genvar c = 0; c < NCH; c++) begin : g_ch

    state_t           state_q, state_d;
    logic [CBITS-1:0] cnt_q, cnt_d;
    logic [CBITS-1:0] per_q;
    logic             err_q, err_d;

    // Counter position relative to the period. Exactly one of these is high.
    logic at_tc, below_tc, over_tc;

    assign at_tc    = (cnt_q == per_q);
    assign below_tc = (cnt_q <  per_q);
    assign over_tc  = (cnt_q >  per_q);

    // -------------------------------------------------------------------------
    // State register (also holds counter, period and sticky error)
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        per_q   <= RST_P;
        err_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        err_q   <= err_d;
        // A new period takes effect from the cycle after the write edge; this
        // edge's transition was decided with the old period.
        if (wr_hit[c]) begin
          per_q <= wr_data;
        end
      end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (en[c]) begin
            state_d = ST_COUNT;
          end
        end

        ST_COUNT: begin
          if (!en[c]) begin
            // Dropping enable abandons the count; a pulse already showing
            // this cycle is not suppressed.
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (below_tc) begin
            // cnt < P, so the increment cannot exceed P and never wraps.
            cnt_d = cnt_q + CBITS'(1);
          end else begin
            // Terminal count or overrun: both restart from zero. Only a
            // genuine terminal count can complete a one-shot.
            cnt_d = '0;
            if (at_tc && mode[c]) begin
              state_d = ST_DONE;
            end
          end
        end

        ST_DONE: begin
          cnt_d = '0;
          if (!en[c]) begin
            state_d = ST_IDLE;
          end
        end

        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // Overrun sets the sticky error; a set in the same cycle as a clear wins.
    assign err_d = (err_q & ~err_clr[c]) | ((state_q == ST_COUNT) & over_tc);

    // -------------------------------------------------------------------------
    // Output logic, purely from registered state
    // -------------------------------------------------------------------------
    logic sig_c, flg_c, done_c;

    always_comb begin
      sig_c  = 1'b0;
      flg_c  = 1'b0;
      done_c = 1'b0;
      unique case (state_q)
        ST_COUNT: begin
          sig_c = at_tc;
          flg_c = below_tc;
        end
        ST_DONE: begin
          done_c = 1'b1;
        end
        default: begin
          sig_c  = 1'b0;
          flg_c  = 1'b0;
          done_c = 1'b0;
        end
      endcase
    end

    assign sig[c]  = sig_c;
    assign flg[c]  = flg_c;
    assign done[c] = done_c;
    assign err[c]  = err_q;

  end : g_ch

endmodule : multi_delay
